i2s_rx_10xe_deserializer: RTL and testbench
===========================================

// Module: i2s_rx_10xe_deserializer
// PURPOSE
//  Downstream consumer of the I2S transmitter serial outputs (sclk_out, lrclk_out, sdata_0_out).
//  - Oversamples the serial lines on aud_mclk and recovers left/right audio words, MSB first, Philips I2S timing.
//  - Buffers recovered words in a small FIFO and presents them on an AXI-Stream master.
//  - Used as a loopback checker: recovered words are compared against the stream fed to the transmitter.
// PARAMETERS
//  DATA_WIDTH  24  captured bits per channel word (8..32)
//  FIFO_DEPTH  4   output FIFO entries, power of 2, >=2
// PORTS
//  aud_mclk            in   1             audio master clock; sole clock
//  aud_mrst_n          in   1             reset, asynchronous assert, active-low
//  en                  in   1             receiver enable; 0 = IDLE, FIFO flushed
//  sclk_in             in   1             I2S serial clock (async to aud_mclk)
//  lrclk_in            in   1             word select: 0 = left, 1 = right
//  sdata_in            in   1             I2S serial data
//  m_axis_aud_tdata    out  DATA_WIDTH    recovered sample
//  m_axis_aud_tid      out  1             channel of sample: 0 left, 1 right
//  m_axis_aud_tvalid   out  1             FIFO not empty
//  m_axis_aud_tready   in   1             sink accepts
//  sts_clr             in   1             1-cycle pulse, clears sticky flags
//  ovf_err             out  1             sticky: word dropped, FIFO full
//  frame_err           out  1             sticky: slot shorter than DATA_WIDTH
//  irq                 out  1             ovf_err | frame_err
//  fifo_level          out  $clog2(FIFO_DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, FIFO empty, synchronizers 0.
//  - Input sync: sclk_in, lrclk_in, sdata_in each pass a 2-FF synchronizer.
//    - sclk rise = sync2 & ~sync3; lrclk/sdata sampled from sync2 on that cycle.
//    - aud_mclk must be >= 4x sclk.
//  - FSM:
//    - IDLE: en=0; bit_cnt=0; FIFO flushed. en=1 -> ARM.
//    - ARM: waits for the first sclk rise whose lrclk differs from prev_lr (prev_lr updated on every rise).
//      On that edge: the partial slot is discarded, bit_cnt=0 -> RUN.
//    - RUN, each sclk rise:
//      - lrclk == prev_lr: shift the bit in while bit_cnt < DATA_WIDTH; bit_cnt saturates at DATA_WIDTH; later bits ignored.
//      - lrclk != prev_lr (boundary): the bit on this edge is the LSB of the finishing slot; treat it as a normal bit first.
//        - Slot complete: total bits = bit_cnt+1 (incl. this bit).
//        - total >= DATA_WIDTH: push {word, tid=prev_lr}.
//        - total < DATA_WIDTH: no push; set frame_err.
//        - Reset bit_cnt=0 and shift register; the next rise carries the MSB of the new slot.
//    - en 1->0 in any state -> IDLE next cycle; in-flight word and FIFO contents lost; sticky flags kept.
//  - Latency: push occurs 1 aud_mclk after the boundary-edge detect.
//    - tvalid rises the cycle after the push; total 4 aud_mclk from the sclk_in pin edge.
//  - FIFO: pop on tvalid & tready. tdata/tid are stable while tvalid=1 & tready=0.
//    - Push while full with no pop: word dropped, ovf_err set.
//    - Push while full with a same-cycle pop: both occur, no overflow.
//    - Pointers wrap modulo FIFO_DEPTH.
//  - Sticky flags: set has priority over sts_clr in the same cycle. irq is combinational OR of the registered flags.
//  - Async reset mid-word: immediate clear; next frame requires re-arm, i.e. a fresh lrclk change.
// TESTING
//  - Reset: assert aud_mrst_n=0 mid-traffic -> all outputs 0 asynchronously; after release, first partial slot not emitted.
//  - Stereo words: DATA_WIDTH=24, 32-bit slots, L=24'hA5A5A5, R=24'h5A5A5A, sclk=mclk/8, tready=1
//    -> stream (A5A5A5,tid0),(5A5A5A,tid1); 8 LSB padding bits ignored.
//  - Exact-length slot: 24-bit slots, L=24'h800001 -> tdata 24'h800001; boundary LSB captured correctly.
//  - Short slot: 16-bit slots -> no words pushed; frame_err=1, irq=1; sts_clr pulse clears both.
//  - Backpressure: tready=0 for 6 words, FIFO_DEPTH=4 -> fifo_level=4, ovf_err=1, first 4 words intact in order.
//    - Also: full + push with same-cycle pop -> no ovf_err.
//  - Enable drop: en=0 mid-slot for 10 cycles then en=1 -> FIFO empty, no word until a full slot follows the first lrclk change.

Source files
------------

// File: rtl/i2s_rx_10xe_deserializer.sv
// I2S (Philips timing) receiver: oversamples sclk/lrclk/sdata on aud_mclk, recovers
// left/right words MSB first and queues them into a small FIFO behind an AXI-Stream master.
module i2s_rx_10xe_deserializer #(
   parameter int DATA_WIDTH = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          aud_mclk,
   input  logic                          aud_mrst_n,
   input  logic                          en,
   input  logic                          sclk_in,
   input  logic                          lrclk_in,
   input  logic                          sdata_in,
   output logic [DATA_WIDTH-1:0]         m_axis_aud_tdata,
   output logic                          m_axis_aud_tid,
   output logic                          m_axis_aud_tvalid,
   input  logic                          m_axis_aud_tready,
   input  logic                          sts_clr,
   output logic                          ovf_err,
   output logic                          frame_err,
   output logic                          irq,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);
   localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

   state_t                  state, state_nxt;
   logic [2:0]              sclk_sync;
   logic [1:0]              lr_sync, sd_sync;
   logic                    rise, lr, sd, prev_lr, boundary, frame_set, ovf_set;
   logic [CW-1:0]           bit_cnt;
   logic [DATA_WIDTH-1:0]   shreg, shift_word;
   logic                    push_vld, push_tid;
   logic [DATA_WIDTH-1:0]   push_data;
   logic [DATA_WIDTH:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic [AW:0]             count;
   logic                    full, pop, wr;

   assign rise       = sclk_sync[1] & ~sclk_sync[2];
   assign lr         = lr_sync[1];
   assign sd         = sd_sync[1];
   assign boundary   = rise & (lr != prev_lr);
   assign shift_word = {shreg[DATA_WIDTH-2:0], sd};

   always_ff @(posedge aud_mclk or negedge aud_mrst_n) begin
      if (!aud_mrst_n) begin
         sclk_sync <= '0;
         lr_sync   <= '0;
         sd_sync   <= '0;
         state     <= IDLE;
      end else begin
         sclk_sync <= {sclk_sync[1:0], sclk_in};
         lr_sync   <= {lr_sync[0], lrclk_in};
         sd_sync   <= {sd_sync[0], sdata_in};
         state     <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      frame_set = 1'b0;
      if (!en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = ARM;
            ARM:     if (boundary) state_nxt = RUN;
            RUN:     frame_set = boundary && (bit_cnt < LAST_CNT);
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Slot assembly: the boundary edge carries the LSB of the slot that is finishing.
   always_ff @(posedge aud_mclk or negedge aud_mrst_n) begin
      if (!aud_mrst_n) begin
         prev_lr   <= 1'b0;
         bit_cnt   <= '0;
         shreg     <= '0;
         push_vld  <= 1'b0;
         push_tid  <= 1'b0;
         push_data <= '0;
      end else begin
         push_vld <= 1'b0;
         if (rise) prev_lr <= lr;
         if (state == RUN && en) begin
            if (boundary) begin
               if (bit_cnt >= LAST_CNT) begin
                  push_vld  <= 1'b1;
                  push_tid  <= prev_lr;
                  push_data <= (bit_cnt < FULL_CNT) ? shift_word : shreg;
               end
               bit_cnt <= '0;
               shreg   <= '0;
            end else if (rise && bit_cnt < FULL_CNT) begin
               shreg   <= shift_word;
               bit_cnt <= bit_cnt + CW'(1);
            end
         end else begin
            bit_cnt <= '0;
            shreg   <= '0;
         end
      end
   end

   assign full    = (count == DEPTH);
   assign pop     = m_axis_aud_tvalid & m_axis_aud_tready;
   assign wr      = en & push_vld & (~full | pop);
   assign ovf_set = en & push_vld & full & ~pop;

   always_ff @(posedge aud_mclk or negedge aud_mrst_n) begin
      if (!aud_mrst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (!en) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= {push_tid, push_data};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({wr, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Setting a flag wins over a same-cycle clear.
   always_ff @(posedge aud_mclk or negedge aud_mrst_n) begin
      if (!aud_mrst_n) begin
         ovf_err   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         ovf_err   <= ovf_set | (ovf_err & ~sts_clr);
         frame_err <= frame_set | (frame_err & ~sts_clr);
      end
   end

   assign {m_axis_aud_tid, m_axis_aud_tdata} = mem[rd_ptr];
   assign m_axis_aud_tvalid = (count != '0);
   assign fifo_level        = count;
   assign irq               = ovf_err | frame_err;
endmodule

// File: tb/tb_i2s_rx_10xe_deserializer.sv
// Bench for the I2S receiver: drives Philips-timed serial streams (sclk = mclk/8) and
// checks recovered words through an expected-word queue plus per-scenario flag checks.
module tb_i2s_rx_10xe_deserializer;
   logic clk = 0, rst_n = 1, en = 0, sclk = 0, lrclk = 0, sdata = 0, tready = 0, sts_clr = 0;
   logic [23:0] tdata;
   logic        tid, tvalid, ovf, ferr, irq;
   logic [2:0]  level;

   typedef struct packed { logic [23:0] d; logic t; } exp_t;
   exp_t exp_q[$];
   bit   tx_ch[$];
   bit   tx_bit[$];
   int   mark_idx = -1;
   event mark_ev;
   bit   cur_lr = 0;
   int   passed = 0, total = 0;

   i2s_rx_10xe_deserializer #(.DATA_WIDTH(24), .FIFO_DEPTH(4)) dut (
      .aud_mclk(clk), .aud_mrst_n(rst_n), .en(en), .sclk_in(sclk), .lrclk_in(lrclk),
      .sdata_in(sdata), .m_axis_aud_tdata(tdata), .m_axis_aud_tid(tid),
      .m_axis_aud_tvalid(tvalid), .m_axis_aud_tready(tready), .sts_clr(sts_clr),
      .ovf_err(ovf), .frame_err(ferr), .irq(irq), .fifo_level(level));

   always #5 clk = ~clk;

   // Scoreboard: every accepted beat must match the oldest expected word.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && tvalid && tready) begin
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL stream_word: got %h/tid%b, required no word", tdata, tid);
         end else begin
            e = exp_q.pop_front();
            if ({tdata, tid} !== {e.d, e.t})
               $display("FAIL stream_word: got %h/tid%b, required %h/tid%b", tdata, tid, e.d, e.t);
            else passed++;
         end
      end
   end

   function automatic void add_bits(bit ch, logic [31:0] w, int nbits, int dbits);
      for (int i = 0; i < nbits; i++) begin
         tx_ch.push_back(ch);
         tx_bit.push_back((i < dbits) ? w[dbits-1-i] : 1'b1);
      end
   endfunction

   function automatic void add_slot(bit ch, logic [23:0] w, int nbits, bit expect_it);
      exp_t e;
      add_bits(ch, {8'h00, w}, nbits, (nbits < 24) ? nbits : 24);
      e.d = w;
      e.t = ch;
      if (expect_it) exp_q.push_back(e);
   endfunction

   // Lead bits keep the current lrclk level, so the first lrclk change marks the first real slot.
   function automatic void add_lead();
      add_bits(cur_lr, 32'h5, 3, 3);
   endfunction

   function automatic void add_trail();
      add_bits(!tx_ch[tx_ch.size()-1], 32'h3, 2, 2);
   endfunction

   // lrclk leads the data by one bit: during a slot's LSB it already shows the next channel.
   task automatic send_stream();
      for (int n = 0; n < tx_bit.size(); n++) begin
         @(posedge clk); #1;
         sclk  = 0;
         lrclk = (n + 1 < tx_bit.size()) ? tx_ch[n+1] : tx_ch[n];
         sdata = tx_bit[n];
         repeat (4) @(posedge clk);
         #1 sclk = 1;
         if (n == mark_idx) -> mark_ev;
         repeat (3) @(posedge clk);
      end
      @(posedge clk); #1 sclk = 0;
      cur_lr = lrclk;
      tx_bit.delete();
      tx_ch.delete();
      mark_idx = -1;
   endtask

   task automatic restart();
      @(posedge clk); #1 en = 0;
      repeat (3) @(posedge clk);
      #1 en = 1;
      repeat (3) @(posedge clk);
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1 sts_clr = 1;
      @(posedge clk); #1 sts_clr = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2 rst_n = 0;
      #6;
      total += 7;
      if (tdata !== 24'h0) $display("FAIL rst_tdata: got %h, required 0", tdata); else passed++;
      if (tid !== 1'b0)    $display("FAIL rst_tid: got %b, required 0", tid); else passed++;
      if (tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b, required 0", tvalid); else passed++;
      if (ovf !== 1'b0)    $display("FAIL rst_ovf: got %b, required 0", ovf); else passed++;
      if (ferr !== 1'b0)   $display("FAIL rst_frame: got %b, required 0", ferr); else passed++;
      if (irq !== 1'b0)    $display("FAIL rst_irq: got %b, required 0", irq); else passed++;
      if (level !== 3'd0)  $display("FAIL rst_level: got %0d, required 0", level); else passed++;
      @(posedge clk); #1 rst_n = 1;
      repeat (2) @(posedge clk);
      #1 en = 1;
      repeat (3) @(posedge clk);
      // Mid-traffic reset inside the second slot: first word is lost, the partial slot is skipped.
      tready = 0;
      add_lead();
      add_slot(1, 24'hC3C3C3, 24, 0);
      add_slot(0, 24'h111111, 24, 0);
      add_slot(1, 24'h2468AC, 24, 1);
      add_slot(0, 24'hFEDCBA, 24, 1);
      add_trail();
      mark_idx = 35;
      fork
         send_stream();
         begin
            @(mark_ev);
            repeat (2) @(posedge clk);
            #1;
            total += 5;
            if (tvalid !== 1'b1) $display("FAIL pre_rst_tvalid: got %b, required 1", tvalid); else passed++;
            if (tdata !== 24'hC3C3C3) $display("FAIL pre_rst_tdata: got %h, required c3c3c3", tdata); else passed++;
            #1 rst_n = 0;
            #1;
            if (tvalid !== 1'b0) $display("FAIL async_rst_tvalid: got %b, required 0", tvalid); else passed++;
            if (tdata !== 24'h0) $display("FAIL async_rst_tdata: got %h, required 0", tdata); else passed++;
            if (level !== 3'd0)  $display("FAIL async_rst_level: got %0d, required 0", level); else passed++;
            #20 rst_n = 1;
         end
      join
      tready = 1;
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      total += 2;
      if (exp_q.size() != 0) $display("FAIL reset_drain: %0d words missing, required 0", exp_q.size()); else passed++;
      if (ferr !== 1'b0) $display("FAIL reset_frame: got %b, required 0", ferr); else passed++;
   endtask

   task automatic test_stereo();
      restart();
      tready = 1;
      add_lead();
      add_slot(0, 24'hA5A5A5, 32, 1);
      add_slot(1, 24'h5A5A5A, 32, 1);
      add_trail();
      send_stream();
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      total += 3;
      if (exp_q.size() != 0) $display("FAIL stereo_drain: %0d words missing, required 0", exp_q.size()); else passed++;
      if (ferr !== 1'b0)  $display("FAIL stereo_frame: got %b, required 0", ferr); else passed++;
      if (level !== 3'd0) $display("FAIL stereo_level: got %0d, required 0", level); else passed++;
   endtask

   task automatic test_exact();
      restart();
      tready = 1;
      add_lead();
      add_slot(1, 24'h123456, 24, 1);
      add_slot(0, 24'h800001, 24, 1);
      add_trail();
      send_stream();
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      total += 2;
      if (exp_q.size() != 0) $display("FAIL exact_drain: %0d words missing, required 0", exp_q.size()); else passed++;
      if (ferr !== 1'b0) $display("FAIL exact_frame: got %b, required 0", ferr); else passed++;
   endtask

   task automatic test_short();
      restart();
      tready = 1;
      add_lead();
      add_slot(0, 24'h00ABCD, 16, 0);
      add_slot(1, 24'h001234, 16, 0);
      add_slot(0, 24'h00F00F, 16, 0);
      add_trail();
      send_stream();
      repeat (5) @(posedge clk);
      #1;
      total += 6;
      if (ferr !== 1'b1)   $display("FAIL short_frame: got %b, required 1", ferr); else passed++;
      if (irq !== 1'b1)    $display("FAIL short_irq: got %b, required 1", irq); else passed++;
      if (level !== 3'd0)  $display("FAIL short_level: got %0d, required 0", level); else passed++;
      if (ovf !== 1'b0)    $display("FAIL short_ovf: got %b, required 0", ovf); else passed++;
      pulse_clr();
      if (ferr !== 1'b0)   $display("FAIL short_clr_frame: got %b, required 0", ferr); else passed++;
      if (irq !== 1'b0)    $display("FAIL short_clr_irq: got %b, required 0", irq); else passed++;
   endtask

   task automatic test_backpressure();
      restart();
      tready = 0;
      add_lead();
      add_slot(0, 24'h100001, 24, 1);
      add_slot(1, 24'h200002, 24, 1);
      add_slot(0, 24'h300003, 24, 1);
      add_slot(1, 24'h400004, 24, 1);
      add_slot(0, 24'h500005, 24, 0);
      add_slot(1, 24'h600006, 24, 0);
      add_trail();
      send_stream();
      repeat (5) @(posedge clk);
      #1;
      total += 4;
      if (level !== 3'd4)  $display("FAIL bp_level: got %0d, required 4", level); else passed++;
      if (ovf !== 1'b1)    $display("FAIL bp_ovf: got %b, required 1", ovf); else passed++;
      if (irq !== 1'b1)    $display("FAIL bp_irq: got %b, required 1", irq); else passed++;
      if (tdata !== 24'h100001) $display("FAIL bp_head: got %h, required 100001", tdata); else passed++;
      tready = 1;
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      total += 3;
      if (exp_q.size() != 0) $display("FAIL bp_drain: %0d words missing, required 0", exp_q.size()); else passed++;
      pulse_clr();
      if (ovf !== 1'b0)    $display("FAIL bp_clr_ovf: got %b, required 0", ovf); else passed++;
      if (level !== 3'd0)  $display("FAIL bp_end_level: got %0d, required 0", level); else passed++;
   endtask

   // FIFO full; the fifth word's push lands on the single cycle tready is high.
   task automatic test_full_pop();
      restart();
      tready = 0;
      add_lead();
      add_slot(1, 24'hA00000, 24, 1);
      add_slot(0, 24'hA11111, 24, 1);
      add_slot(1, 24'hA22222, 24, 1);
      add_slot(0, 24'hA33333, 24, 1);
      add_slot(1, 24'hA44444, 24, 1);
      add_trail();
      mark_idx = 3 + 5 * 24 - 1;
      fork
         send_stream();
         begin
            @(mark_ev);
            repeat (3) @(posedge clk);
            #1 tready = 1;
            @(posedge clk);
            #1 tready = 0;
         end
      join
      repeat (3) @(posedge clk);
      #1;
      total += 3;
      if (ovf !== 1'b0)    $display("FAIL fullpop_ovf: got %b, required 0", ovf); else passed++;
      if (level !== 3'd4)  $display("FAIL fullpop_level: got %0d, required 4", level); else passed++;
      tready = 1;
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      if (exp_q.size() != 0) $display("FAIL fullpop_drain: %0d words missing, required 0", exp_q.size()); else passed++;
   endtask

   task automatic test_enable_drop();
      restart();
      tready = 0;
      add_lead();
      add_slot(1, 24'h0BAD01, 24, 0);
      add_slot(0, 24'h0BAD02, 24, 0);
      add_slot(1, 24'hC0FFEE, 24, 1);
      add_slot(0, 24'hBEEF42, 24, 1);
      add_trail();
      mark_idx = 3 + 24 + 12;
      fork
         send_stream();
         begin
            @(mark_ev);
            @(posedge clk); #1;
            total += 3;
            if (level !== 3'd1) $display("FAIL en_pre_level: got %0d, required 1", level); else passed++;
            en = 0;
            repeat (10) @(posedge clk);
            #1 en = 1;
            @(posedge clk); #1;
            if (level !== 3'd0)  $display("FAIL en_flush_level: got %0d, required 0", level); else passed++;
            if (tvalid !== 1'b0) $display("FAIL en_flush_tvalid: got %b, required 0", tvalid); else passed++;
         end
      join
      tready = 1;
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      total += 2;
      if (exp_q.size() != 0) $display("FAIL en_drain: %0d words missing, required 0", exp_q.size()); else passed++;
      if (ferr !== 1'b0) $display("FAIL en_frame: got %b, required 0", ferr); else passed++;
   endtask

   initial begin
      test_reset();
      test_stereo();
      test_exact();
      test_short();
      test_backpressure();
      test_full_pop();
      test_enable_drop();
      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
